// File: rtl/bp_common_pkg.sv
// Shared types for the BlackParrot LCE request arbiter.
// Holds default widths, the FIFO entry layout and the round-robin step helper.
package bp_common_pkg;

    localparam int lce_req_msg_width_lp    = 16;
    localparam int lce_req_arb_num_src_lp  = 2;
    localparam int lce_req_arb_tag_width_lp = $clog2(lce_req_arb_num_src_lp);

    typedef struct packed {
        logic [lce_req_arb_tag_width_lp-1:0] src;
        logic [lce_req_msg_width_lp-1:0]     msg;
    } bp_lce_req_arb_entry_s;

    function automatic int rr_next(input int k, input int n);
        return (k + 1) % n;
    endfunction

endpackage

// File: rtl/bp_lce_req_rr_arb.sv
// Round-robin grant generator with a registered priority pointer.
// Grants nothing while en_i is low; the pointer only moves on a grant.
module bp_lce_req_rr_arb
    import bp_common_pkg::*;
#(
    parameter int num_src_p = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 en_i,
    input  logic [num_src_p-1:0] v_i,
    output logic [num_src_p-1:0] grant_o
);

    localparam int ptr_w = $clog2(num_src_p);

    logic [ptr_w-1:0] ptr_r;
    logic [ptr_w-1:0] ptr_n;
    logic [ptr_w-1:0] idx;
    logic             found;

    always_comb begin
        grant_o = '0;
        ptr_n   = ptr_r;
        found   = 1'b0;
        idx     = '0;
        for (int i = 0; i < num_src_p; i++) begin
            idx = ptr_w'((int'(ptr_r) + i) % num_src_p);
            if (en_i && !found && v_i[idx]) begin
                grant_o[idx] = 1'b1;
                ptr_n        = ptr_w'(rr_next(int'(idx), num_src_p));
                found        = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_r <= '0;
        end else begin
            ptr_r <= ptr_n;
        end
    end

endmodule

// File: rtl/bp_lce_req_arbiter.sv
// Merges per-core LCE request channels onto one NoC request port through
// a small tagged FIFO, with saturating per-source grant counters.
module bp_lce_req_arbiter
    import bp_common_pkg::*;
#(
    parameter int num_src_p   = 2,
    parameter int msg_width_p = lce_req_msg_width_lp,
    parameter int fifo_els_p  = 2,
    parameter int cnt_width_p = 16
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic [num_src_p-1:0][msg_width_p-1:0] req_i,
    input  logic [num_src_p-1:0]                  req_v_i,
    output logic [num_src_p-1:0]                  req_yumi_o,
    output logic [msg_width_p-1:0]                req_o,
    output logic [$clog2(num_src_p)-1:0]          req_src_o,
    output logic                                  req_v_o,
    input  logic                                  req_ready_i,
    output logic [num_src_p-1:0][cnt_width_p-1:0] grant_cnt_o
);

    localparam int tag_w = $clog2(num_src_p);
    localparam int ptr_w = $clog2(fifo_els_p);
    localparam int occ_w = $clog2(fifo_els_p + 1);

    typedef struct packed {
        logic [tag_w-1:0]       src;
        logic [msg_width_p-1:0] msg;
    } entry_s;

    entry_s               mem_r [fifo_els_p];
    entry_s               wr_entry;
    logic [ptr_w-1:0]     wptr_r;
    logic [ptr_w-1:0]     rptr_r;
    logic [occ_w-1:0]     occ_r;
    logic [num_src_p-1:0] grant;
    logic                 full;
    logic                 empty;
    logic                 enq;
    logic                 deq;

    // Full comes from registered occupancy, so ready never reaches yumi.
    assign full  = (occ_r == occ_w'(fifo_els_p));
    assign empty = (occ_r == '0);

    bp_lce_req_rr_arb #(
        .num_src_p(num_src_p)
    ) u_arb (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .en_i   (~full & ~reset_i),
        .v_i    (req_v_i),
        .grant_o(grant)
    );

    assign req_yumi_o = grant;
    assign enq        = |grant;
    assign req_v_o    = ~empty & ~reset_i;
    assign deq        = req_v_o & req_ready_i;
    assign req_o      = mem_r[rptr_r].msg;
    assign req_src_o  = mem_r[rptr_r].src;

    always_comb begin
        wr_entry = '0;
        for (int i = 0; i < num_src_p; i++) begin
            if (grant[i]) begin
                wr_entry.src = tag_w'(i);
                wr_entry.msg = req_i[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_r[wptr_r] <= wr_entry;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_r <= '0;
            rptr_r <= '0;
            occ_r  <= '0;
        end else begin
            if (enq) begin
                wptr_r <= (wptr_r == ptr_w'(fifo_els_p - 1))
                        ? '0 : wptr_r + ptr_w'(1);
            end
            if (deq) begin
                rptr_r <= (rptr_r == ptr_w'(fifo_els_p - 1))
                        ? '0 : rptr_r + ptr_w'(1);
            end
            unique case ({enq, deq})
                2'b10:   occ_r <= occ_r + occ_w'(1);
                2'b01:   occ_r <= occ_r - occ_w'(1);
                default: occ_r <= occ_r;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            grant_cnt_o <= '0;
        end else begin
            for (int k = 0; k < num_src_p; k++) begin
                if (grant[k] && (grant_cnt_o[k] != '1)) begin
                    grant_cnt_o[k] <= grant_cnt_o[k] + cnt_width_p'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_bp_lce_req_arbiter.sv
// Randomized bench for bp_lce_req_arbiter with a queue-based reference model
// and directed literal checks for reset, alternation, backpressure and saturation.
module tb_bp_lce_req_arbiter;

    localparam int N    = 2;
    localparam int W    = 16;
    localparam int FIFO = 2;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic                clk;
    logic                reset_i;
    logic [N-1:0][W-1:0] req_i;
    logic [N-1:0]        req_v_i;
    logic [N-1:0]        req_yumi_o;
    logic [W-1:0]        req_o;
    logic [0:0]          req_src_o;
    logic                req_v_o;
    logic                req_ready_i;
    logic [N-1:0][CW-1:0] grant_cnt_o;

    int checks = 0;
    int errors = 0;

    bp_lce_req_arbiter #(
        .num_src_p  (N),
        .msg_width_p(W),
        .fifo_els_p (FIFO),
        .cnt_width_p(CW)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .req_i      (req_i),
        .req_v_i    (req_v_i),
        .req_yumi_o (req_yumi_o),
        .req_o      (req_o),
        .req_src_o  (req_src_o),
        .req_v_o    (req_v_o),
        .req_ready_i(req_ready_i),
        .grant_cnt_o(grant_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", n, a, e, $time);
        end
    endtask

    typedef struct {
        int          src;
        logic [W-1:0] msg;
    } ent_t;

    ent_t q[$];
    int   m_ptr = 0;
    int   m_cnt[N];

    // Reference model: checks the current cycle, then advances to the
    // state the DUT will hold after the next rising edge.
    always @(negedge clk) begin : model
        int   k;
        int   s;
        ent_t e;
        logic [N-1:0] ey;
        logic ev;
        k = -1;
        if (!reset_i && q.size() < FIFO) begin
            for (int o = 0; o < N; o++) begin
                s = (m_ptr + o) % N;
                if (k < 0 && req_v_i[s]) k = s;
            end
        end
        ey = '0;
        if (k >= 0) ey[k] = 1'b1;
        ev = !reset_i && q.size() > 0;
        chk("yumi", 32'(req_yumi_o), 32'(ey));
        chk("v_o", 32'(req_v_o), 32'(ev));
        if (ev) begin
            chk("req_o", 32'(req_o), 32'(q[0].msg));
            chk("src_o", 32'(req_src_o), q[0].src);
        end
        for (int j = 0; j < N; j++)
            chk($sformatf("cnt%0d", j), 32'(grant_cnt_o[j]), m_cnt[j]);
        if (reset_i) begin
            q.delete();
            m_ptr = 0;
            for (int j = 0; j < N; j++) m_cnt[j] = 0;
        end else begin
            if (q.size() > 0 && req_ready_i) void'(q.pop_front());
            if (k >= 0) begin
                e.src = k;
                e.msg = req_i[k];
                q.push_back(e);
                m_ptr = (k + 1) % N;
                if (m_cnt[k] < CMAX) m_cnt[k]++;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int j = 0; j < N; j++) m_cnt[j] = 0;
        reset_i     = 1'b1;
        req_v_i     = 2'b11;
        req_ready_i = 1'b1;
        req_i[0]    = 16'h1000;
        req_i[1]    = 16'h2000;

        // Reset holds everything quiet even with both sources valid.
        repeat (2) begin
            cyc();
            #2;
            chk("rst_yumi", 32'(req_yumi_o), 32'h0);
            chk("rst_v_o", 32'(req_v_o), 32'h0);
        end

        // Alternation with output always ready.
        for (int i = 0; i < 8; i++) begin
            cyc();
            reset_i  = 1'b0;
            req_i[0] = W'(16'h1000 + i);
            req_i[1] = W'(16'h2000 + i);
            #2;
            chk("alt_yumi", 32'(req_yumi_o), (i % 2) ? 32'h2 : 32'h1);
            if (i > 0) chk("alt_src", 32'(req_src_o), (i - 1) % 2);
        end
        cyc();
        req_v_i = 2'b00;
        #2;
        chk("alt_cnt0", 32'(grant_cnt_o[0]), 32'd4);
        chk("alt_cnt1", 32'(grant_cnt_o[1]), 32'd4);

        // Backpressure: two accepts fill the FIFO, then yumi stops.
        cyc();
        req_ready_i = 1'b0;
        req_v_i     = 2'b10;
        req_i[1]    = 16'h000A;
        #2;
        chk("bp_acc0", 32'(req_yumi_o), 32'h2);
        cyc();
        req_i[1] = 16'h000B;
        #2;
        chk("bp_acc1", 32'(req_yumi_o), 32'h2);
        for (int i = 0; i < 2; i++) begin
            cyc();
            #2;
            chk("bp_full_yumi", 32'(req_yumi_o), 32'h0);
            chk("bp_hold_msg", 32'(req_o), 32'h000A);
        end

        // Full with ready and both valid: dequeue only, then grant at ptr.
        cyc();
        req_ready_i = 1'b1;
        req_v_i     = 2'b11;
        #2;
        chk("full_rdy_yumi", 32'(req_yumi_o), 32'h0);
        chk("full_rdy_msg", 32'(req_o), 32'h000A);
        cyc();
        #2;
        chk("after_full_yumi", 32'(req_yumi_o), 32'h1);
        chk("drain_order", 32'(req_o), 32'h000B);

        // Single source back-to-back, then source 0 wins immediately.
        for (int i = 0; i < 5; i++) begin
            cyc();
            req_v_i  = 2'b10;
            req_i[1] = W'(16'h3000 + i);
            #2;
            chk("single_yumi", 32'(req_yumi_o), 32'h2);
        end
        cyc();
        req_v_i = 2'b11;
        #2;
        chk("ptr_back_yumi", 32'(req_yumi_o), 32'h1);

        // Counter saturation on source 0.
        for (int i = 0; i < 20; i++) begin
            cyc();
            req_v_i  = 2'b01;
            req_i[0] = W'(16'h4000 + i);
        end
        cyc();
        req_v_i = 2'b00;
        #2;
        chk("sat_cnt0", 32'(grant_cnt_o[0]), 32'd15);

        // Random traffic with occasional mid-flight resets.
        for (int i = 0; i < 3000; i++) begin
            cyc();
            reset_i     = ($urandom_range(0, 63) == 0);
            req_v_i     = N'($urandom_range(0, 3));
            req_ready_i = ($urandom_range(0, 9) < 6);
            req_i[0]    = W'($urandom);
            req_i[1]    = W'($urandom);
        end

        cyc();
        reset_i = 1'b0;
        req_v_i = '0;
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
